iir_sample_feeder: RTL and testbench
====================================

IIR_SAMPLE_FEEDER -- requirements
Module: iir_sample_feeder

Interface
REQ-001 SHALL provide parameter LAST_ADDR, default 11'd2047: highest input-RAM address read per run; run length N = LAST_ADDR+1.
REQ-002 SHALL provide clk, input, 1, rising-edge clock.
REQ-003 SHALL provide rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL provide start, input, 1, begin a run; sampled in IDLE only.
REQ-005 SHALL provide abort, input, 1, synchronous cancel of a run in progress.
REQ-006 SHALL provide pipeline_en, input, 1, filter-controller enable; gates issue of new RAM reads.
REQ-007 SHALL provide rd_en, output, 1, input-RAM read strobe.
REQ-008 SHALL provide rd_addr, output, 11, input-RAM read address.
REQ-009 SHALL provide rd_data, input, 16, RAM read data, valid exactly one cycle after rd_en.
REQ-010 SHALL provide data_out, output, 16, sample presented to the SOS pipeline.
REQ-011 SHALL provide data_valid, output, 1, data_out holds a valid sample.
REQ-012 SHALL provide ready, input, 1, pipeline accepts data_out this cycle.
REQ-013 SHALL provide busy, output, 1, high in FETCH and DRAIN.
REQ-014 SHALL provide done, output, 1, one-cycle pulse when all N samples have been transferred.
REQ-015 SHALL provide sample_count, output, 12, count of completed transfers in the current or last run.

Function
REQ-016 SHALL use states IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE->FETCH on start=1; FETCH->DRAIN in the cycle the read of LAST_ADDR issues; DRAIN->DONE when sample_count reaches N; DONE->IDLE unconditionally.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL clear rd_addr and sample_count on the IDLE->FETCH transition.
REQ-020 SHALL hold a 2-entry FIFO; rd_data is written into it on the edge following the cycle with rd_en=1.
REQ-021 SHALL assert rd_en (combinational) only when state=FETCH, pipeline_en=1 and (occupancy + in-flight read − pop this cycle) < 2.
REQ-022 SHALL increment rd_addr by 1 per issued read; LAST_ADDR is the final read and rd_addr does not wrap.
REQ-023 SHALL drive data_valid = FIFO non-empty and data_out = FIFO head.
REQ-024 A transfer occurs when data_valid & ready; it pops the FIFO and increments sample_count.
REQ-025 Once data_valid=1, data_out SHALL stay stable until the transfer completes, regardless of pipeline_en.
REQ-026 With ready=1 and pipeline_en=1 held, throughput SHALL be 1 sample/cycle, and data_valid SHALL first assert 2 edges after the edge that samples start.
REQ-027 pipeline_en=0 SHALL stall reads only; queued samples continue to drain while ready=1.
REQ-028 SHALL pulse done for exactly the DONE cycle; sample_count SHALL hold N afterwards until the next start.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge, flush the FIFO, discard any in-flight read data, and SHALL NOT pulse done.
REQ-030 If start and abort are high together in IDLE, abort SHALL win and the block stays in IDLE.
REQ-031 SHALL never issue a read beyond LAST_ADDR and never present more than N samples per run.

Reset
REQ-032 rst_n=0 SHALL force IDLE, FIFO empty, and all outputs 0 (rd_en, rd_addr, data_out, data_valid, busy, done, sample_count).
REQ-033 Deasserting rst_n mid-run SHALL leave the block in IDLE awaiting start.

Verification
REQ-034 Basic run: start pulse, ready=1, pipeline_en=1, RAM[i]=i -> data_out 0..2047 on consecutive cycles, done pulse once, sample_count=2048.
REQ-035 Backpressure: ready toggles 1/0 each cycle -> no sample lost or duplicated, data_out stable while ready=0, rd_en never issues with occupancy+in-flight >= 2.
REQ-036 Enable gap: pipeline_en=0 for 10 cycles after sample 100 -> rd_en=0 during the gap, queued samples still drain, sequence continuous afterwards.
REQ-037 Abort: abort at sample 500 -> IDLE next cycle, data_valid=0, no done; a new start restarts from address 0.
REQ-038 Boundaries: LAST_ADDR=0 -> exactly one read at address 0, one transfer, done; start held high during DONE -> a new run begins only from IDLE.
REQ-039 Reset mid-run: rst_n pulsed low at sample 1000 -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/iir_sample_feeder_if.sv
// iir_sample_feeder_if: input-RAM read port plus the valid/ready sample
// stream toward the SOS pipeline. The feeder is the master of both.
interface iir_sample_feeder_if;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] data_out;
    logic        data_valid;
    logic        ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output data_out,
        output data_valid,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  data_out,
        input  data_valid,
        output ready
    );
endinterface

// File: rtl/iir_sample_feeder.sv
// iir_sample_feeder: reads LAST_ADDR+1 samples from a synchronous input RAM
// (one-cycle read latency) and presents them to the SOS pipeline through a
// 2-entry FIFO with a valid/ready handshake. Reads are throttled so that
// queued plus in-flight samples never exceed the FIFO depth.
module iir_sample_feeder #(
    parameter logic [10:0] LAST_ADDR = 11'd2047
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                pipeline_en,
    output logic                busy,
    output logic                done,
    output logic [11:0]         sample_count,
    iir_sample_feeder_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Count value just before the final transfer of a run (N-1).
    localparam logic [11:0] LAST_COUNT = {1'b0, LAST_ADDR};

    state_t      state_q, state_d;
    logic [10:0] rd_addr_q, rd_addr_d;
    logic [11:0] count_q, count_d;
    logic        busy_q, done_q;

    logic [15:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  occ_q;
    logic        inflight_q;

    logic        valid_s, xfer_s, rd_en_s;
    logic [1:0]  pending_s;

    // Handshake decode and read-issue gating against FIFO room.
    always_comb begin
        valid_s   = (occ_q != 2'd0);
        xfer_s    = valid_s & bus.ready;
        pending_s = occ_q + {1'b0, inflight_q} - {1'b0, xfer_s};
        if ((state_q == FETCH) && pipeline_en && (pending_s < 2'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state, read-address and transfer-count computation.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = FETCH;
                        rd_addr_d = 11'd0;
                        count_d   = 12'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    if (rd_en_s && (rd_addr_q == LAST_ADDR)) begin
                        state_d = DRAIN;
                    end else if (rd_en_s) begin
                        rd_addr_d = rd_addr_q + 11'd1;
                    end else begin
                        rd_addr_d = rd_addr_q;
                    end
                    if (xfer_s) begin
                        count_d = count_q + 12'd1;
                    end else begin
                        count_d = count_q;
                    end
                end
                DRAIN: begin
                    if (xfer_s) begin
                        count_d = count_q + 12'd1;
                        if (count_q == LAST_COUNT) begin
                            state_d = DONE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control FSM with registered busy/done status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= 11'd0;
            count_q   <= 12'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            busy_q    <= (state_d == FETCH) || (state_d == DRAIN);
            done_q    <= (state_d == DONE);
        end
    end

    // Sample FIFO: capture RAM data the cycle after a read, pop on transfer;
    // abort flushes queued entries and drops the outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= 16'd0;
            fifo_q[1]  <= 16'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else if (abort) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en_s;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (xfer_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, xfer_s};
        end
    end

    assign bus.rd_en      = rd_en_s;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.data_out   = fifo_q[rd_ptr_q];
    assign bus.data_valid = valid_s;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sample_count   = count_q;
endmodule

// File: tb/tb_iir_sample_feeder.sv
// tb_iir_sample_feeder: drives two feeders (default depth and LAST_ADDR=0)
// against a synchronous RAM model. A transaction-level reference model of
// the default instance is compared with its outputs on every cycle, and
// directed literal checks pin latency, reset and boundary behaviour.
module tb_iir_sample_feeder;
    localparam int N0  = 2048;
    localparam int LA0 = 2047;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0, pen0 = 1'b0;
    logic        start1 = 1'b0, abort1 = 1'b0, pen1 = 1'b0;
    logic        busy0, done0, busy1, done1;
    logic [11:0] cnt0, cnt1;
    logic [15:0] ram [N0];

    int n_chk  = 0;
    int n_fail = 0;
    int n_done0 = 0;

    iir_sample_feeder_if bus0 ();
    iir_sample_feeder_if bus1 ();

    iir_sample_feeder dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .pipeline_en(pen0), .busy(busy0), .done(done0),
        .sample_count(cnt0), .bus(bus0)
    );

    iir_sample_feeder #(.LAST_ADDR(11'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .pipeline_en(pen1), .busy(busy1), .done(done1),
        .sample_count(cnt1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Input RAMs with one-cycle read latency.
    always_ff @(posedge clk) begin
        if (bus0.rd_en) bus0.rd_data <= ram[bus0.rd_addr];
    end

    // Second RAM port for the single-sample instance.
    always_ff @(posedge clk) begin
        if (bus1.rd_en) bus1.rd_data <= ram[bus1.rd_addr];
    end

    // ---------------- reference model (dut0) ----------------
    // Phases: 0 idle, 1 fetching, 2 draining, 3 done.
    int          m_phase  = 0;
    logic [15:0] m_fifo [$];
    bit          m_infl   = 1'b0;
    logic [15:0] m_infl_data = 16'd0;
    int          m_issued = 0;
    int          m_count  = 0;

    function automatic bit m_valid();
        return m_fifo.size() != 0;
    endfunction

    function automatic bit m_rd_en();
        int pend;
        pend = m_fifo.size() + int'(m_infl) - int'(m_valid() && bus0.ready);
        return (m_phase == 1) && pen0 && (pend < 2);
    endfunction

    function automatic int m_addr();
        return (m_issued > LA0) ? LA0 : m_issued;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_fifo.delete(); m_infl = 1'b0;
        m_issued = 0; m_count = 0;
    endtask

    task automatic m_step();
        bit xfer, issue;
        xfer  = m_valid() && bus0.ready;
        issue = m_rd_en();
        if (abort0) begin
            m_phase = 0; m_fifo.delete(); m_infl = 1'b0;
        end else begin
            if (xfer) begin
                void'(m_fifo.pop_front());
                m_count++;
            end
            if (m_infl) m_fifo.push_back(m_infl_data);
            m_infl = issue;
            if (issue) begin
                m_infl_data = ram[m_issued];
                m_issued++;
            end
            case (m_phase)
                0: if (start0) begin m_phase = 1; m_count = 0; m_issued = 0; end
                1: if (issue && (m_issued == N0)) m_phase = 2;
                2: if (m_count == N0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of dut0 against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("rd_en", bus0.rd_en, m_rd_en());
            chk("rd_addr", bus0.rd_addr, m_addr());
            chk("data_valid", bus0.data_valid, m_valid());
            if (!rst_n) chk("data_out_reset", bus0.data_out, 0);
            else if (m_valid()) chk("data_out", bus0.data_out, m_fifo[0]);
            chk("busy", busy0, (m_phase == 1) || (m_phase == 2));
            chk("done", done0, m_phase == 3);
            chk("sample_count", cnt0, m_count);
            if (done0) n_done0++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int mode);
        case (mode)
            0: begin bus0.ready = 1'b1; pen0 = 1'b1; end
            1: begin bus0.ready = ~bus0.ready; pen0 = 1'b1; end
            default: begin
                bus0.ready = 1'($urandom_range(0, 1));
                pen0 = ($urandom_range(0, 3) != 0);
            end
        endcase
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic run_until_count(input int target, input int budget, input int mode);
        int k = 0;
        while ((int'(cnt0) < target) && (k < budget)) begin
            set_inputs(mode);
            tick();
            k++;
        end
        chk("reach_count", int'(cnt0) >= target, 1);
    endtask

    task automatic run_to_done(input int budget, input int mode, output int k);
        k = 0;
        while (!done0 && (k < budget)) begin
            set_inputs(mode);
            tick();
            k++;
        end
        chk("done_seen", done0, 1);
    endtask

    initial begin
        int k, d0, r, x, d;
        bus0.ready = 1'b0;
        bus1.ready = 1'b0;
        for (int i = 0; i < N0; i++) ram[i] = 16'(i);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_valid", bus0.data_valid, 0);
        chk("rst_addr", bus0.rd_addr, 0);
        chk("rst_data", bus0.data_out, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic run, RAM[i]=i, full throughput
        pen0 = 1'b1; bus0.ready = 1'b1;
        pulse_start0();
        chk("first_rd_en", bus0.rd_en, 1);
        chk("first_rd_addr", bus0.rd_addr, 0);
        chk("first_valid_e0", bus0.data_valid, 0);
        chk("busy_fetch", busy0, 1);
        tick();
        chk("valid_e1", bus0.data_valid, 0);
        chk("addr_e1", bus0.rd_addr, 1);
        tick();
        chk("valid_e2", bus0.data_valid, 1);
        chk("data_e2", bus0.data_out, 16'd0);
        tick();
        chk("data_e3", bus0.data_out, 16'd1);
        run_to_done(3000, 0, k);
        chk("done_latency", k, 2047);
        chk("final_count", cnt0, 12'd2048);
        tick();
        chk("done_one_cycle", done0, 0);
        chk("idle_after_done", busy0, 0);
        chk("count_holds", cnt0, 12'd2048);
        chk("basic_done_pulses", n_done0, 1);

        // Backpressure: ready toggles every cycle, random RAM data
        for (int i = 0; i < N0; i++) ram[i] = 16'($urandom);
        pulse_start0();
        run_to_done(6000, 1, k);
        chk("bp_count", cnt0, 12'd2048);
        tick();

        // Enable gap after sample 100
        bus0.ready = 1'b1; pen0 = 1'b1;
        pulse_start0();
        run_until_count(100, 500, 0);
        pen0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gap_rd_en", bus0.rd_en, 0);
        end
        chk("gap_drained", cnt0, 12'd102);
        chk("gap_valid", bus0.data_valid, 0);
        pen0 = 1'b1;
        run_to_done(3000, 0, k);
        chk("gap_count", cnt0, 12'd2048);
        tick();

        // Abort at sample 500
        for (int i = 0; i < N0; i++) ram[i] = 16'($urandom);
        pulse_start0();
        run_until_count(500, 1000, 0);
        d0 = n_done0;
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("abort_valid", bus0.data_valid, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_rd_en", bus0.rd_en, 0);
        repeat (5) tick();
        chk("abort_no_done", n_done0, d0);

        // start and abort together in IDLE: abort wins
        start0 = 1'b1; abort0 = 1'b1;
        tick();
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_idle", busy0, 0);
        tick();
        chk("start_abort_idle2", busy0, 0);

        // Restart from address 0 with random handshakes
        pulse_start0();
        chk("restart_rd_en", bus0.rd_en, 1);
        chk("restart_addr", bus0.rd_addr, 0);
        chk("restart_count", cnt0, 0);
        k = 0;
        while ((m_phase != 2) && (k < 8000)) begin
            set_inputs(2);
            tick();
            k++;
        end
        start0 = 1'b1;
        run_to_done(2000, 2, k);
        tick();
        chk("done_to_idle", busy0, 0);
        tick();
        chk("start_from_idle", busy0, 1);
        chk("start_from_idle_cnt", cnt0, 0);
        start0 = 1'b0;

        // Reset mid-run at sample 1000
        run_until_count(1000, 3000, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_en", bus0.rd_en, 0);
        chk("mrst_rd_addr", bus0.rd_addr, 0);
        chk("mrst_data", bus0.data_out, 0);
        chk("mrst_valid", bus0.data_valid, 0);
        chk("mrst_busy", busy0, 0);
        chk("mrst_done", done0, 0);
        chk("mrst_count", cnt0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", busy0, 0);
        end
        pulse_start0();
        chk("post_rst_start", busy0, 1);
        chk("post_rst_addr", bus0.rd_addr, 0);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;

        // LAST_ADDR=0 instance: exactly one read/transfer/done
        ram[0] = 16'hBEEF;
        pen1 = 1'b1; bus1.ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        r = 0; x = 0; d = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus1.rd_en) begin
                r++;
                chk("la0_addr", bus1.rd_addr, 0);
            end
            if (bus1.data_valid && bus1.ready) begin
                x++;
                chk("la0_data", bus1.data_out, 16'hBEEF);
            end
            if (done1) d++;
            tick();
        end
        chk("la0_reads", r, 1);
        chk("la0_xfers", x, 1);
        chk("la0_dones", d, 1);
        chk("la0_count", cnt1, 12'd1);

        // start held high: runs restart only after passing through IDLE
        start1 = 1'b1;
        d = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (done1) d++;
        end
        start1 = 1'b0;
        chk("la0_held_dones", d, 2);
        repeat (8) tick();
        chk("la0_final_idle", busy1, 0);
        chk("la0_final_count", cnt1, 12'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
